optimsoc_config_regs: RTL and testbench

Read-mostly Wishbone B3 classic slave exposing a tile's derived `config_t` and its tile ID to software. It is the consumer end of the configuration path: `derive_config` produces the structure at elaboration time, and this block serves it over the tile bus so runtime code discovers tile count, compute-tile list, memory sizes and feature flags. It sits on the tile bus next to the network adapter. It adds one scratch register and one error counter.

---
 rtl/optimsoc_config_regs_pkg.sv | 86 ++++++++
 rtl/optimsoc_config_regs.sv | 126 ++++++++++++
 tb/tb_optimsoc_config_regs.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/optimsoc_config_regs_pkg.sv
// Shared types, register map and FEATURES encoding for the tile configuration register block.
package optimsoc_config_regs_pkg;

  typedef enum logic [0:0] {Plain, External} lmem_style_e;

  // Field names follow derive_config so both ends of the configuration path agree.
  typedef struct packed {
    logic [31:0]          NUMTILES;
    logic [31:0]          NUMCTS;
    logic [63:0][15:0]    CTLIST;
    logic [31:0]          CORES_PER_TILE;
    logic [31:0]          TOTAL_NUM_CORES;
    logic [31:0]          GMEM_SIZE;
    logic [31:0]          GMEM_TILE;
    lmem_style_e          LMEM_STYLE;
    logic [31:0]          LMEM_SIZE;
    logic                 ENABLE_BOOTROM;
    logic                 ENABLE_DM;
    logic [31:0]          DM_BASE;
    logic [31:0]          DM_SIZE;
    logic                 ENABLE_PGAS;
    logic [31:0]          PGAS_BASE;
    logic [31:0]          PGAS_SIZE;
    logic                 CORE_ENABLE_FPU;
    logic                 CORE_ENABLE_PERFCOUNTERS;
    logic                 NA_ENABLE_MPSIMPLE;
    logic                 NA_ENABLE_DMA;
    logic                 NA_DMA_GENIRQ;
    logic [31:0]          NA_DMA_ENTRIES;
    logic                 USE_DEBUG;
    logic [31:0]          DEBUG_NUM_MODS;
    logic                 NOC_ENABLE_VCHANNELS;
  } config_t;

  localparam logic [31:0] VERSION = 32'h0000_0001;

  localparam logic [15:0] RegVersion      = 16'h0000;
  localparam logic [15:0] RegTileid       = 16'h0004;
  localparam logic [15:0] RegNumtiles     = 16'h0008;
  localparam logic [15:0] RegCoresPerTile = 16'h000C;
  localparam logic [15:0] RegTotalCores   = 16'h0010;
  localparam logic [15:0] RegLmemSize     = 16'h0014;
  localparam logic [15:0] RegGmemSize     = 16'h0018;
  localparam logic [15:0] RegGmemTile     = 16'h001C;
  localparam logic [15:0] RegFeatures     = 16'h0020;
  localparam logic [15:0] RegNumcts       = 16'h0024;
  localparam logic [15:0] RegNaDmaEntries = 16'h0028;
  localparam logic [15:0] RegDmBase       = 16'h002C;
  localparam logic [15:0] RegDmSize       = 16'h0030;
  localparam logic [15:0] RegPgasBase     = 16'h0034;
  localparam logic [15:0] RegPgasSize     = 16'h0038;
  localparam logic [15:0] RegDebugNumMods = 16'h003C;
  localparam logic [15:0] RegScratch      = 16'h0040;
  localparam logic [15:0] RegErrcnt       = 16'h0044;
  localparam logic [15:0] RegCtlistBase   = 16'h0200;

  localparam int unsigned FeatEnableBootrom     = 0;
  localparam int unsigned FeatEnableDm          = 1;
  localparam int unsigned FeatEnablePgas        = 2;
  localparam int unsigned FeatCoreFpu           = 3;
  localparam int unsigned FeatCorePerfcounters  = 4;
  localparam int unsigned FeatNaMpsimple        = 5;
  localparam int unsigned FeatNaDma             = 6;
  localparam int unsigned FeatNaDmaGenirq       = 7;
  localparam int unsigned FeatUseDebug          = 8;
  localparam int unsigned FeatNocVchannels      = 9;
  localparam int unsigned FeatLmemPlain         = 10;

  function automatic logic [31:0] features(config_t cfg);
    logic [31:0] f;
    f = '0;
    f[FeatEnableBootrom]    = cfg.ENABLE_BOOTROM;
    f[FeatEnableDm]         = cfg.ENABLE_DM;
    f[FeatEnablePgas]       = cfg.ENABLE_PGAS;
    f[FeatCoreFpu]          = cfg.CORE_ENABLE_FPU;
    f[FeatCorePerfcounters] = cfg.CORE_ENABLE_PERFCOUNTERS;
    f[FeatNaMpsimple]       = cfg.NA_ENABLE_MPSIMPLE;
    f[FeatNaDma]            = cfg.NA_ENABLE_DMA;
    f[FeatNaDmaGenirq]      = cfg.NA_DMA_GENIRQ;
    f[FeatUseDebug]         = cfg.USE_DEBUG;
    f[FeatNocVchannels]     = cfg.NOC_ENABLE_VCHANNELS;
    f[FeatLmemPlain]        = (cfg.LMEM_STYLE == Plain);
    return f;
  endfunction

endpackage

// File: rtl/optimsoc_config_regs.sv
// Wishbone B3 classic slave serving the tile's derived configuration, a scratch register and a
// saturating bus-error counter. Every accepted request terminates with exactly one ack or err.
module optimsoc_config_regs
  import optimsoc_config_regs_pkg::*;
#(
  parameter config_t     CONFIG = 'x,
  parameter int unsigned TILEID = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o
);

  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  errcnt_q, errcnt_d;

  logic [15:0] adr_w;
  logic        req;
  logic        rd_hit;
  logic [31:0] rd_val;
  logic        unused_adr;

  assign adr_w      = {wb_adr_i[15:2], 2'b00};
  assign unused_adr = ^wb_adr_i[1:0];
  // The response cycle masks the still-high strobe so a single request never acks twice.
  assign req        = wb_cyc_i & wb_stb_i & ~ack_q & ~err_q;

  always_comb begin
    rd_hit = 1'b1;
    rd_val = '0;
    case (adr_w)
      RegVersion:      rd_val = VERSION;
      RegTileid:       rd_val = 32'(TILEID);
      RegNumtiles:     rd_val = CONFIG.NUMTILES;
      RegCoresPerTile: rd_val = CONFIG.CORES_PER_TILE;
      RegTotalCores:   rd_val = CONFIG.TOTAL_NUM_CORES;
      RegLmemSize:     rd_val = CONFIG.LMEM_SIZE;
      RegGmemSize:     rd_val = CONFIG.GMEM_SIZE;
      RegGmemTile:     rd_val = CONFIG.GMEM_TILE;
      RegFeatures:     rd_val = features(CONFIG);
      RegNumcts:       rd_val = CONFIG.NUMCTS;
      RegNaDmaEntries: rd_val = CONFIG.NA_DMA_ENTRIES;
      RegDmBase:       rd_val = CONFIG.DM_BASE;
      RegDmSize:       rd_val = CONFIG.DM_SIZE;
      RegPgasBase:     rd_val = CONFIG.PGAS_BASE;
      RegPgasSize:     rd_val = CONFIG.PGAS_SIZE;
      RegDebugNumMods: rd_val = CONFIG.DEBUG_NUM_MODS;
      RegScratch:      rd_val = scratch_q;
      RegErrcnt:       rd_val = {24'h0, errcnt_q};
      default: begin
        // CTLIST window 0x200..0x2FC; entries past NUMCTS are served unchecked.
        if (adr_w[15:8] == RegCtlistBase[15:8]) begin
          rd_val = {16'h0, CONFIG.CTLIST[adr_w[7:2]]};
        end else begin
          rd_hit = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    ack_d     = 1'b0;
    err_d     = 1'b0;
    dat_d     = dat_q;
    scratch_d = scratch_q;
    errcnt_d  = errcnt_q;
    if (req) begin
      if (wb_we_i) begin
        if (adr_w == RegScratch) begin
          ack_d = 1'b1;
          for (int b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) scratch_d[8*b +: 8] = wb_dat_i[8*b +: 8];
          end
        end else if (adr_w == RegErrcnt) begin
          ack_d    = 1'b1;
          errcnt_d = '0;
        end else begin
          err_d = 1'b1;
        end
      end else if (rd_hit) begin
        ack_d = 1'b1;
        dat_d = rd_val;
      end else begin
        err_d = 1'b1;
      end
      if (err_d) begin
        dat_d = '0;
        if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      scratch_q <= '0;
      errcnt_q  <= '0;
    end else begin
      ack_q     <= ack_d;
      err_q     <= err_d;
      dat_q     <= dat_d;
      scratch_q <= scratch_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_dat_o = dat_q;
  assign wb_rty_o = 1'b0;

endmodule

// File: tb/tb_optimsoc_config_regs.sv
// Directed bench for optimsoc_config_regs: register map, scratch byte enables, error counting,
// saturation, strobe-held throughput and asynchronous reset during a response.
module tb_optimsoc_config_regs;
  import optimsoc_config_regs_pkg::*;

  function automatic config_t tb_cfg();
    config_t c;
    c = '0;
    c.NUMTILES                 = 32'd8;
    c.NUMCTS                   = 32'd4;
    c.CTLIST[0]                = 16'd0;
    c.CTLIST[1]                = 16'd1;
    c.CTLIST[2]                = 16'd3;
    c.CTLIST[3]                = 16'd5;
    c.CTLIST[63]               = 16'hBEEF;
    c.CORES_PER_TILE           = 32'd2;
    c.TOTAL_NUM_CORES          = 32'd8;
    c.GMEM_SIZE                = 32'h0100_0000;
    c.GMEM_TILE                = 32'd7;
    c.LMEM_STYLE               = Plain;
    c.LMEM_SIZE                = 32'h0001_0000;
    c.ENABLE_BOOTROM           = 1'b1;
    c.ENABLE_DM                = 1'b0;
    c.ENABLE_PGAS              = 1'b1;
    c.CORE_ENABLE_FPU          = 1'b1;
    c.CORE_ENABLE_PERFCOUNTERS = 1'b0;
    c.NA_ENABLE_MPSIMPLE       = 1'b1;
    c.NA_ENABLE_DMA            = 1'b1;
    c.NA_DMA_GENIRQ            = 1'b0;
    c.NA_DMA_ENTRIES           = 32'd4;
    c.USE_DEBUG                = 1'b1;
    c.DEBUG_NUM_MODS           = 32'd6;
    c.NOC_ENABLE_VCHANNELS     = 1'b0;
    return c;
  endfunction

  localparam config_t TbConfig = tb_cfg();

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        wb_rty_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  optimsoc_config_regs #(
    .CONFIG(TbConfig),
    .TILEID(3)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .wb_rty_o (wb_rty_o)
  );

  // One single-beat transfer: *1 is the cycle after the sampling edge, *2 the cycle after that.
  task automatic bus(input logic we, input logic [15:0] adr, input logic [31:0] wdat,
                     input logic [3:0] sel, output logic ack1, output logic err1,
                     output logic [31:0] rdat, output logic ack2, output logic err2);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = wdat;
    wb_sel_i = sel;
    @(posedge clk);
    #1;
    ack1 = wb_ack_o;
    err1 = wb_err_o;
    rdat = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    ack2 = wb_ack_o;
    err2 = wb_err_o;
  endtask

  task automatic test_reset();
    logic a1, e1, a2, e2;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o} !== 35'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ack=%b err=%b rty=%b dat=%h, want all 0",
               wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o);
    end
    rst = 1'b0;
    bus(1'b0, RegScratch, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_scratch: got ack=%b dat=%h, want ack=1 dat=00000000", a1, d);
    end
    bus(1'b0, RegErrcnt, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_errcnt: got ack=%b dat=%h, want ack=1 dat=00000000", a1, d);
    end
  endtask

  task automatic test_id_regs();
    logic [15:0] adrs [5] = '{16'h0000, 16'h0004, 16'h0010, 16'h0020, 16'h0014};
    logic [31:0] exps [5] = '{32'h1, 32'h3, 32'h8, 32'h0000_056D, 32'h0001_0000};
    logic a1, e1, a2, e2;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, adrs[i], 32'h0, 4'h0, a1, e1, d, a2, e2);
      n_checks++;
      if (a1 !== 1'b1 || e1 !== 1'b0 || d !== exps[i]) begin
        n_fail++;
        $display("FAIL id_read[%h]: got ack=%b err=%b dat=%h, want ack=1 err=0 dat=%h",
                 adrs[i], a1, e1, d, exps[i]);
      end
      n_checks++;
      if (a2 !== 1'b0 || e2 !== 1'b0) begin
        n_fail++;
        $display("FAIL id_ack_width[%h]: got ack=%b err=%b next cycle, want 0 0",
                 adrs[i], a2, e2);
      end
    end
  endtask

  task automatic test_ctlist();
    logic [15:0] adrs [5] = '{16'h0200, 16'h0204, 16'h0208, 16'h020C, 16'h02FC};
    logic [31:0] exps [5] = '{32'd0, 32'd1, 32'd3, 32'd5, 32'h0000_BEEF};
    logic a1, e1, a2, e2;
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      bus(1'b0, adrs[i], 32'h0, 4'h0, a1, e1, d, a2, e2);
      n_checks++;
      if (a1 !== 1'b1 || e1 !== 1'b0 || d !== exps[i]) begin
        n_fail++;
        $display("FAIL ctlist[%h]: got ack=%b err=%b dat=%h, want ack=1 err=0 dat=%h",
                 adrs[i], a1, e1, d, exps[i]);
      end
    end
  endtask

  task automatic test_scratch();
    logic a1, e1, a2, e2;
    logic [31:0] d;
    bus(1'b1, RegScratch, 32'hAABB_CCDD, 4'b0101, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL scratch_write_resp: got ack=%b err=%b, want ack=1 err=0", a1, e1);
    end
    bus(1'b0, RegScratch, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'h00BB_00DD) begin
      n_fail++;
      $display("FAIL scratch_readback: got ack=%b dat=%h, want ack=1 dat=00bb00dd", a1, d);
    end
  endtask

  task automatic test_errors();
    logic a1, e1, a2, e2;
    logic [31:0] d;
    bus(1'b1, RegNumtiles, 32'h1, 4'hF, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b0 || e1 !== 1'b1 || d !== 32'h0 || e2 !== 1'b0) begin
      n_fail++;
      $display("FAIL ro_write: got ack=%b err=%b dat=%h err_next=%b, want 0 1 00000000 0",
               a1, e1, d, e2);
    end
    bus(1'b0, 16'h0100, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b0 || e1 !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL unmapped_read: got ack=%b err=%b dat=%h, want 0 1 00000000", a1, e1, d);
    end
    bus(1'b0, RegNumtiles, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'd8) begin
      n_fail++;
      $display("FAIL ro_unchanged: got ack=%b dat=%h, want ack=1 dat=00000008", a1, d);
    end
    bus(1'b0, RegErrcnt, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'd2) begin
      n_fail++;
      $display("FAIL errcnt_two: got ack=%b dat=%h, want ack=1 dat=00000002", a1, d);
    end
    bus(1'b1, RegErrcnt, 32'hFFFF_FFFF, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || e1 !== 1'b0) begin
      n_fail++;
      $display("FAIL errcnt_clear_resp: got ack=%b err=%b, want ack=1 err=0", a1, e1);
    end
    bus(1'b0, RegErrcnt, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'd0) begin
      n_fail++;
      $display("FAIL errcnt_cleared: got ack=%b dat=%h, want ack=1 dat=00000000", a1, d);
    end
  endtask

  task automatic test_saturation();
    logic a1, e1, a2, e2;
    logic [31:0] d;
    for (int i = 0; i < 300; i++) begin
      bus(1'b0, 16'h0300, 32'h0, 4'h0, a1, e1, d, a2, e2);
    end
    bus(1'b0, RegErrcnt, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'd255) begin
      n_fail++;
      $display("FAIL errcnt_saturate: got ack=%b dat=%h, want ack=1 dat=000000ff", a1, d);
    end
  endtask

  task automatic test_back_to_back();
    int   acks = 0;
    int   adjacent = 0;
    int   both = 0;
    logic prev = 1'b0;
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = RegVersion;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (wb_ack_o === 1'b1) acks++;
      if (wb_ack_o === 1'b1 && prev === 1'b1) adjacent++;
      if (wb_ack_o === 1'b1 && wb_err_o === 1'b1) both++;
      prev = wb_ack_o;
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    n_checks++;
    if (acks !== 5) begin
      n_fail++;
      $display("FAIL held_stb_acks: got %0d acks in 10 cycles, want 5", acks);
    end
    n_checks++;
    if (adjacent !== 0 || both !== 0) begin
      n_fail++;
      $display("FAIL held_stb_shape: got adjacent=%0d ack_and_err=%0d, want 0 0",
               adjacent, both);
    end
  endtask

  task automatic test_reset_mid_response();
    logic a1, e1, a2, e2;
    logic [31:0] d;
    bus(1'b1, RegScratch, 32'h1234_5678, 4'hF, a1, e1, d, a2, e2);
    @(negedge clk);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = RegScratch;
    @(posedge clk);
    #1;
    n_checks++;
    if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL pre_reset_read: got ack=%b dat=%h, want ack=1 dat=12345678",
               wb_ack_o, wb_dat_o);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: got ack=%b dat=%h, want ack=0 dat=00000000",
               wb_ack_o, wb_dat_o);
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus(1'b0, RegScratch, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL scratch_after_reset: got ack=%b dat=%h, want ack=1 dat=00000000", a1, d);
    end
    bus(1'b0, RegErrcnt, 32'h0, 4'h0, a1, e1, d, a2, e2);
    n_checks++;
    if (a1 !== 1'b1 || d !== 32'h0) begin
      n_fail++;
      $display("FAIL errcnt_after_reset: got ack=%b dat=%h, want ack=1 dat=00000000", a1, d);
    end
  endtask

  initial begin
    test_reset();
    test_id_regs();
    test_ctlist();
    test_scratch();
    test_errors();
    test_saturation();
    test_back_to_back();
    test_reset_mid_response();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
